// File: rtl/debouncer_multi.sv
// Multi-channel push-button conditioner: per channel a two-flop synchroniser,
// symmetric press/release debounce, single-cycle press/release pulses,
// long-press detection and optional auto-repeat while the button is held.
module debouncer_multi #(
  parameter int NCH           = 4,
  parameter int DEB_CYCLES    = 500000,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int REPEAT_EN     = 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [NCH-1:0] pb,
  output logic [NCH-1:0] pressed_state,
  output logic [NCH-1:0] pressed_pulse,
  output logic [NCH-1:0] released_pulse,
  output logic [NCH-1:0] long_press_pulse,
  output logic [NCH-1:0] repeat_pulse
);

  localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int DEB_W    = $clog2(DEB_CYCLES + 1);
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  // Debounce ends on the last counted cycle; the long press fires when the
  // hold counter (0 in the press cycle) reaches HOLD_CYCLES; after that the
  // counter reloads to 0 and a repeat fires each time it reaches REPEAT-1.
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CNT_P = 3'd1;
  localparam logic [2:0] S_PE    = 3'd2;
  localparam logic [2:0] S_HELD  = 3'd3;
  localparam logic [2:0] S_CNT_R = 3'd4;
  localparam logic [2:0] S_NE    = 3'd5;

  logic [NCH-1:0] sync_p0;
  logic [NCH-1:0] sync_p1;

  // Two-flop synchroniser for the asynchronous button inputs
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= pb;
      sync_p1 <= sync_p0;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [2:0]        state;
    logic [DEB_W-1:0]  deb_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              long_done;
    logic              s;
    logic              held;
    logic              long_hit;
    logic              rep_hit;

    assign s        = sync_p1[g];
    assign held     = (state == S_PE) || (state == S_HELD) || (state == S_CNT_R);
    assign long_hit = held && !long_done && (hold_cnt == HOLD_LAST);
    assign rep_hit  = (REPEAT_EN != 0) && held && long_done && (hold_cnt == REP_LAST);

    // Debounce state machine; the counter restarts from 0 on every entry
    // into a counting state
    always_ff @(posedge clock) begin
      if (reset) begin
        state   <= S_IDLE;
        deb_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            deb_cnt <= '0;
            if (s) state <= S_CNT_P;
          end
          S_CNT_P: begin
            if (!s) begin
              state   <= S_IDLE;
              deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
              state <= S_PE;
            end else begin
              deb_cnt <= deb_cnt + DEB_W'(1);
            end
          end
          S_PE: begin
            state   <= S_HELD;
            deb_cnt <= '0;
          end
          S_HELD: begin
            deb_cnt <= '0;
            if (!s) state <= S_CNT_R;
          end
          S_CNT_R: begin
            if (s) begin
              state   <= S_HELD;
              deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
              state <= S_NE;
            end else begin
              deb_cnt <= deb_cnt + DEB_W'(1);
            end
          end
          S_NE: begin
            state   <= S_IDLE;
            deb_cnt <= '0;
          end
          default: begin
            state   <= S_IDLE;
            deb_cnt <= '0;
          end
        endcase
      end
    end

    // Hold timer: runs while the button is accepted as held (including a
    // pending release), reloads at each long/repeat point, cleared otherwise
    always_ff @(posedge clock) begin
      if (reset) begin
        hold_cnt  <= '0;
        long_done <= 1'b0;
      end else if (!held) begin
        hold_cnt  <= '0;
        long_done <= 1'b0;
      end else if (long_hit) begin
        hold_cnt  <= '0;
        long_done <= 1'b1;
      end else if (long_done) begin
        if (REPEAT_EN != 0) begin
          if (rep_hit) hold_cnt <= '0;
          else         hold_cnt <= hold_cnt + HOLD_W'(1);
        end
      end else begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end

    assign pressed_state[g]    = held;
    assign pressed_pulse[g]    = (state == S_PE);
    assign released_pulse[g]   = (state == S_NE);
    assign long_press_pulse[g] = long_hit;
    assign repeat_pulse[g]     = rep_hit;
  end

endmodule

// File: tb/tb_debouncer_multi.sv
// Bench for debouncer_multi: stimulus pushes expected pulse events
// (cycle, channel, kind) into a queue; a monitor pops one entry per observed
// pulse. Level checks on pressed_state are made directly by the stimulus.
module tb_debouncer_multi;

  localparam int NCH = 4;
  localparam int K_PRESS = 0, K_REL = 1, K_LONG = 2, K_REP = 3;

  logic           clk;
  logic           reset;
  logic [NCH-1:0] pb;
  logic [NCH-1:0] pressed_state;
  logic [NCH-1:0] pressed_pulse;
  logic [NCH-1:0] released_pulse;
  logic [NCH-1:0] long_press_pulse;
  logic [NCH-1:0] repeat_pulse;

  debouncer_multi #(
    .NCH(4), .DEB_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(8), .REPEAT_EN(1)
  ) dut (
    .clock(clk),
    .reset(reset),
    .pb(pb),
    .pressed_state(pressed_state),
    .pressed_pulse(pressed_pulse),
    .released_pulse(released_pulse),
    .long_press_pulse(long_press_pulse),
    .repeat_pulse(repeat_pulse)
  );

  typedef struct {
    int cyc;
    int ch;
    int kind;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc = number of rising edges so far; at a falling edge the current
  // cycle index is cyc-1 and the next edge has index cyc
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc - 1);
    end
  endtask

  task automatic expect_pulse(input int c, input int ch, input int kind);
    exp_t e;
    e.cyc  = c;
    e.ch   = ch;
    e.kind = kind;
    q.push_back(e);
  endtask

  task automatic goto(input int c);
    while (cyc - 1 < c) @(negedge clk);
  endtask

  task automatic monitor();
    logic [NCH-1:0] pv [4];
    exp_t e;
    forever begin
      @(negedge clk);
      pv[0] = pressed_pulse;
      pv[1] = released_pulse;
      pv[2] = long_press_pulse;
      pv[3] = repeat_pulse;
      for (int ch = 0; ch < NCH; ch++) begin
        for (int k = 0; k < 4; k++) begin
          if (pv[k][ch] === 1'b1) begin
            if (q.size() == 0) begin
              check($sformatf("unexpected_pulse ch%0d kind%0d", ch, k), 1, 0);
            end else begin
              e = q.pop_front();
              check("pulse(cycle*16+ch*4+kind)",
                    (cyc - 1) * 16 + ch * 4 + k, e.cyc * 16 + e.ch * 4 + e.kind);
            end
          end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    int e;
    reset = 1'b1;
    pb    = '0;
    fork
      monitor();
    join_none

    // Reset with buttons idle, then with all buttons held
    repeat (3) @(negedge clk);
    check("rst_state", int'(pressed_state), 0);
    check("rst_pulses", int'(pressed_pulse | released_pulse | long_press_pulse | repeat_pulse), 0);
    pb = 4'hF;
    repeat (2) @(negedge clk);
    check("rst_held_state", int'(pressed_state), 0);
    check("rst_held_pulses", int'(pressed_pulse | released_pulse | long_press_pulse | repeat_pulse), 0);

    // Buttons held across reset release: full debounce, then release all
    reset = 1'b0;
    e = cyc;
    for (int ch = 0; ch < NCH; ch++) expect_pulse(e + 6, ch, K_PRESS);
    for (int ch = 0; ch < NCH; ch++) expect_pulse(e + 14, ch, K_REL);
    goto(e + 5);  check("post_rst_state_pre", int'(pressed_state), 0);
    goto(e + 6);  check("post_rst_state_on", int'(pressed_state), 15);
    goto(e + 7);  pb = '0;
    goto(e + 13); check("post_rst_state_rel_pre", int'(pressed_state), 15);
    goto(e + 14); check("post_rst_state_rel", int'(pressed_state), 0);
    goto(e + 20);

    // Channel 0: press, long press, repeats, release just before next repeat
    e = cyc;
    pb[0] = 1'b1;
    expect_pulse(e + 6,  0, K_PRESS);
    expect_pulse(e + 26, 0, K_LONG);
    expect_pulse(e + 34, 0, K_REP);
    expect_pulse(e + 42, 0, K_REP);
    expect_pulse(e + 50, 0, K_REP);
    expect_pulse(e + 58, 0, K_REL);
    goto(e + 5);  check("ch0_state_pre", int'(pressed_state[0]), 0);
    goto(e + 6);  check("ch0_state_on", int'(pressed_state[0]), 1);
    goto(e + 51); pb[0] = 1'b0;
    goto(e + 57); check("ch0_state_rel_pre", int'(pressed_state[0]), 1);
    goto(e + 58); check("ch0_state_rel", int'(pressed_state[0]), 0);
    goto(e + 80);

    // Channel 1: bounces shorter than the debounce window
    for (int i = 0; i < 5; i++) begin
      pb[1] = 1'b1;
      repeat (3) @(negedge clk);
      pb[1] = 1'b0;
      repeat (3) @(negedge clk);
      check("ch1_bounce_state", int'(pressed_state[1]), 0);
    end
    repeat (6) @(negedge clk);
    check("ch1_bounce_final", int'(pressed_state[1]), 0);

    // Channel 2: short release glitch while held is ignored
    e = cyc;
    pb[2] = 1'b1;
    expect_pulse(e + 6,  2, K_PRESS);
    expect_pulse(e + 26, 2, K_LONG);
    expect_pulse(e + 34, 2, K_REP);
    expect_pulse(e + 37, 2, K_REL);
    goto(e + 10); pb[2] = 1'b0;
    goto(e + 12); pb[2] = 1'b1;
    for (int c = e + 11; c <= e + 18; c++) begin
      goto(c);
      check("ch2_glitch_state", int'(pressed_state[2]), 1);
    end
    goto(e + 30); pb[2] = 1'b0;
    goto(e + 36); check("ch2_state_rel_pre", int'(pressed_state[2]), 1);
    goto(e + 37); check("ch2_state_rel", int'(pressed_state[2]), 0);
    goto(e + 50);

    // Channels 0 and 3: reset in the middle of press debounce
    e = cyc;
    pb = 4'b1001;
    goto(e + 3);  reset = 1'b1;
    goto(e + 4);  check("mid_rst_state", int'(pressed_state), 0);
    check("mid_rst_pulses", int'(pressed_pulse | released_pulse | long_press_pulse | repeat_pulse), 0);
    goto(e + 5);  reset = 1'b0;
    e = cyc;
    expect_pulse(e + 6,  0, K_PRESS);
    expect_pulse(e + 6,  3, K_PRESS);
    expect_pulse(e + 14, 0, K_REL);
    expect_pulse(e + 14, 3, K_REL);
    goto(e + 5);  check("dual_state_pre", int'(pressed_state), 0);
    goto(e + 6);  check("dual_state_on", int'(pressed_state), 9);
    goto(e + 7);  pb = '0;
    goto(e + 14); check("dual_state_rel", int'(pressed_state), 0);
    goto(e + 24);

    check("pending_expected_pulses", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
